// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_ctrl
// Purpose  : Seeded LFSR sequencer. Loads a seed via the offline mux path,
//            steps the feedback path a programmed number of times, reports done.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_steps,
    output logic             sel,
    output logic             load_en,
    output logic [WIDTH-1:0] lfsr_q,
    output logic [CNT_W-1:0] step_count,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_LOAD = 2'd1;
    localparam logic [1:0]       c_ST_RUN  = 2'd2;
    localparam logic [1:0]       c_ST_DONE = 2'd3;
    localparam logic [WIDTH-1:0] c_LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_seed;
    logic [CNT_W-1:0] r_steps;
    logic [WIDTH-1:0] r_lfsr;
    logic [CNT_W-1:0] r_step_count;
    logic             r_sel;
    logic             r_load_en;
    logic             r_busy;
    logic             r_done;
    logic             r_seed_err;

    logic             w_fb;
    logic [WIDTH-1:0] w_lfsr_next;
    logic [WIDTH-1:0] w_seed_safe;
    logic [CNT_W-1:0] w_count_inc;

    assign w_fb        = ^(r_lfsr & TAPS);
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    assign w_seed_safe = (r_seed == '0) ? c_LFSR_ONE : r_seed;
    assign w_count_inc = r_step_count + c_CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_seed       <= '0;
            r_steps      <= '0;
            r_lfsr       <= '0;
            r_step_count <= '0;
            r_sel        <= 1'b0;
            r_load_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_seed_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_seed       <= seed;
                        r_steps      <= num_steps;
                        r_step_count <= '0;
                        r_seed_err   <= (seed == '0);
                        r_state      <= c_ST_LOAD;
                        r_sel        <= 1'b0;
                        r_load_en    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end

                c_ST_LOAD: begin
                    if (abort) begin
                        r_state   <= c_ST_IDLE;
                        r_sel     <= 1'b0;
                        r_load_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end else begin
                        r_lfsr <= w_seed_safe;
                        if (r_steps == '0) begin
                            r_state   <= c_ST_DONE;
                            r_sel     <= 1'b0;
                            r_load_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state   <= c_ST_RUN;
                            r_sel     <= 1'b1;
                            r_load_en <= 1'b1;
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                        end
                    end
                end

                c_ST_RUN: begin
                    // Abort freezes the LFSR and counter, and wins over completion.
                    if (abort) begin
                        r_state   <= c_ST_IDLE;
                        r_sel     <= 1'b0;
                        r_load_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end else begin
                        r_lfsr       <= w_lfsr_next;
                        r_step_count <= w_count_inc;
                        if (w_count_inc == r_steps) begin
                            r_state   <= c_ST_DONE;
                            r_sel     <= 1'b0;
                            r_load_en <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_state   <= c_ST_IDLE;
                    r_sel     <= 1'b0;
                    r_load_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end

                default: begin
                    r_state   <= c_ST_IDLE;
                    r_sel     <= 1'b0;
                    r_load_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign sel        = r_sel;
    assign load_en    = r_load_en;
    assign lfsr_q     = r_lfsr;
    assign step_count = r_step_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign seed_err   = r_seed_err;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_ctrl
// Purpose  : Directed self-checking bench for lfsr_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] seed = 4'h0;
    logic [7:0] num_steps = 8'h0;
    logic       sel;
    logic       load_en;
    logic [3:0] lfsr_q;
    logic [7:0] step_count;
    logic       busy;
    logic       done;
    logic       seed_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Hand-derived x^4+x^3+1 sequences; index = edges after the start edge.
    logic [3:0] exp1_lfsr [0:5] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h9};
    logic [7:0] exp1_sc   [0:5] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    logic       exp1_sel  [0:5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp1_done [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp2_lfsr [1:16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                     4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

    lfsr_seq_ctrl #(.WIDTH(4), .TAPS(4'b1100), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .seed       (seed),
        .num_steps  (num_steps),
        .sel        (sel),
        .load_en    (load_en),
        .lfsr_q     (lfsr_q),
        .step_count (step_count),
        .busy       (busy),
        .done       (done),
        .seed_err   (seed_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_lfsr"},     32'(lfsr_q),     32'h0);
        chk({pfx, "_sc"},       32'(step_count), 32'h0);
        chk({pfx, "_sel"},      32'(sel),        32'h0);
        chk({pfx, "_load_en"},  32'(load_en),    32'h0);
        chk({pfx, "_busy"},     32'(busy),       32'h0);
        chk({pfx, "_done"},     32'(done),       32'h0);
        chk({pfx, "_seed_err"}, 32'(seed_err),   32'h0);
    endtask

    // seed=1, 3 steps: done in the 5th cycle after the start edge.
    task automatic run_t1(input string pfx);
        seed      = 4'b0001;
        num_steps = 8'd3;
        start     = 1'b1;
        step();
        chk({pfx, "_e0_busy"},    32'(busy),    32'h1);
        chk({pfx, "_e0_load_en"}, 32'(load_en), 32'h1);
        chk({pfx, "_e0_sel"},     32'(sel),     32'h0);
        chk({pfx, "_e0_lfsr"},    32'(lfsr_q),  32'(exp1_lfsr[0]));
        start     = 1'b0;
        seed      = 4'hF;
        num_steps = 8'd0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("%s_e%0d_lfsr", pfx, i), 32'(lfsr_q),     32'(exp1_lfsr[i]));
            chk($sformatf("%s_e%0d_sc", pfx, i),   32'(step_count), 32'(exp1_sc[i]));
            chk($sformatf("%s_e%0d_sel", pfx, i),  32'(sel),        32'(exp1_sel[i]));
            chk($sformatf("%s_e%0d_done", pfx, i), 32'(done),       32'(exp1_done[i]));
        end
        chk({pfx, "_end_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int         sel_cnt;
        logic [15:0] seen;

        // Reset
        #2 rst_n = 1'b0;
        #1 chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'h0);

        // Test 1
        run_t1("t1");

        // Test 2: full period
        seed      = 4'b0001;
        num_steps = 8'd15;
        start     = 1'b1;
        step();
        start   = 1'b0;
        sel_cnt = 0;
        seen    = 16'h0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (sel) sel_cnt++;
            if (i <= 15) seen[lfsr_q] = 1'b1;
            chk($sformatf("t2_e%0d_lfsr", i), 32'(lfsr_q), 32'(exp2_lfsr[i]));
        end
        chk("t2_done",    32'(done),       32'h1);
        chk("t2_sc",      32'(step_count), 32'd15);
        chk("t2_sel_cnt", 32'(sel_cnt),    32'd15);
        chk("t2_seen",    32'(seen),       32'h0000FFFE);
        step();
        chk("t2_done_off", 32'(done), 32'h0);

        // Test 3: zero seed
        seed      = 4'b0000;
        num_steps = 8'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("t3_seed_err", 32'(seed_err), 32'h1);
        step();
        chk("t3_load_lfsr", 32'(lfsr_q), 32'h1);
        chk("t3_run_sel",   32'(sel),    32'h1);
        step();
        chk("t3_lfsr", 32'(lfsr_q),     32'h2);
        chk("t3_sc",   32'(step_count), 32'h1);
        chk("t3_done", 32'(done),       32'h1);
        step();
        chk("t3_done_off",     32'(done),     32'h0);
        chk("t3_seed_err_stk", 32'(seed_err), 32'h1);

        // Test 4: zero steps, start during DONE ignored
        seed      = 4'b1010;
        num_steps = 8'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("t4_seed_err_clr", 32'(seed_err), 32'h0);
        chk("t4_e0_sel",       32'(sel),      32'h0);
        step();
        chk("t4_done", 32'(done),       32'h1);
        chk("t4_lfsr", 32'(lfsr_q),     32'hA);
        chk("t4_sc",   32'(step_count), 32'h0);
        chk("t4_sel",  32'(sel),        32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_start_in_done", 32'(busy), 32'h0);
        chk("t4_done_off",      32'(done), 32'h0);
        step();
        chk("t4_idle_busy", 32'(busy), 32'h0);

        // Test 5: abort in 2nd RUN cycle, start during RUN ignored
        seed      = 4'b0001;
        num_steps = 8'd10;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        seed  = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        chk("t5_pre_sc", 32'(step_count), 32'h1);
        step();
        abort = 1'b0;
        chk("t5_busy",    32'(busy),       32'h0);
        chk("t5_sel",     32'(sel),        32'h0);
        chk("t5_load_en", 32'(load_en),    32'h0);
        chk("t5_sc",      32'(step_count), 32'h1);
        chk("t5_lfsr",    32'(lfsr_q),     32'h2);
        chk("t5_done",    32'(done),       32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_after%0d_done", i), 32'(done), 32'h0);
            chk($sformatf("t5_after%0d_busy", i), 32'(busy), 32'h0);
        end

        // Test 6: async reset mid-RUN, then repeat test 1
        seed      = 4'b0000;
        num_steps = 8'd10;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("t6_pre_busy",     32'(busy),     32'h1);
        chk("t6_pre_seed_err", 32'(seed_err), 32'h1);
        #3 rst_n = 1'b0;
        #1 chk_reset("t6_rst");
        #2 rst_n = 1'b1;
        step();
        chk("t6_idle_busy", 32'(busy), 32'h0);
        run_t1("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
